// File: rtl/sprite_pixel_mixer.sv
// Two-stage sprite mixer: stage 0 resolves wrapped sprite hits, stage 1 keys/prioritises BRAM colours.
// Define SPRITE_COLLIDE_EN to build the per-frame sprite collision flag.
module sprite_pixel_mixer #(
  parameter int unsigned SCR_W     = 320,
  parameter int unsigned SCR_H     = 240,
  parameter int unsigned SPR_W     = 20,
  parameter int unsigned SPR_H     = 20,
  parameter logic [11:0] KEY_COLOR = 12'h000,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [9:0]  pos_h,
  input  logic [9:0]  pos_v,
  input  logic [9:0]  pos_h_m,
  input  logic [9:0]  pos_v_m,
  input  logic [11:0] pixel,
  input  logic [11:0] pixel_m,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        hsync,
  output logic        vsync,
  output logic        collide
);

  localparam logic [10:0] SW_L  = 11'(SCR_W);
  localparam logic [10:0] SH_L  = 11'(SCR_H);
  localparam logic [10:0] SPW_L = 11'(SPR_W);
  localparam logic [10:0] SPH_L = 11'(SPR_H);

  // Both operands are below the modulus in the visible area, so one subtraction suffices.
  function automatic logic [10:0] wrap_add(input logic [9:0] a, input logic [9:0] b,
                                           input logic [10:0] m);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= m) s = s - m;
    return s;
  endfunction

  logic        hit0_d, hit1_d;
  logic        hit0_q, hit1_q, valid0_q, hs0_q, vs0_q;
  logic        opaque0, opaque1;
  logic [11:0] rgb_d, rgb_q;
  logic        hs1_q, vs1_q;

  always_comb begin
    hit0_d = (wrap_add(h_cnt, pos_h, SW_L) < SPW_L) && (wrap_add(v_cnt, pos_v, SH_L) < SPH_L);
    hit1_d = (wrap_add(h_cnt, pos_h_m, SW_L) < SPW_L) && (wrap_add(v_cnt, pos_v_m, SH_L) < SPH_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit0_q   <= 1'b0;
      hit1_q   <= 1'b0;
      valid0_q <= 1'b0;
      hs0_q    <= 1'b1;
      vs0_q    <= 1'b1;
    end else begin
      hit0_q   <= hit0_d;
      hit1_q   <= hit1_d;
      valid0_q <= valid;
      hs0_q    <= hsync_in;
      vs0_q    <= vsync_in;
    end
  end

  always_comb begin
    opaque0 = hit0_q && (pixel != KEY_COLOR);
    opaque1 = hit1_q && (pixel_m != KEY_COLOR);
    rgb_d   = BG_COLOR;
    if (!valid0_q)    rgb_d = '0;
    else if (opaque0) rgb_d = pixel;
    else if (opaque1) rgb_d = pixel_m;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs1_q <= hs0_q;
      vs1_q <= vs0_q;
    end
  end

  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];
  assign hsync    = hs1_q;
  assign vsync    = vs1_q;

`ifdef SPRITE_COLLIDE_EN
  logic acc_d, acc_q, collide_d, collide_q, coll_px, vs_fall;

  // vs1_q holds the previous stage-0 vsync, so this is a falling edge of stage-0 vsync.
  always_comb begin
    coll_px   = valid0_q && opaque0 && opaque1;
    vs_fall   = vs1_q && !vs0_q;
    acc_d     = acc_q | coll_px;
    collide_d = collide_q;
    if (vs_fall) begin
      collide_d = acc_q;
      acc_d     = coll_px;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign collide = collide_q;
`else
  assign collide = 1'b0;
`endif

endmodule
